// File: rtl/wave_capture_pkg.sv
// Shared definitions for the wave capture stage: default widths, FSM state
// encoding and the zero-crossing predicate.
package wave_capture_pkg;

  localparam int unsigned SAMPLE_WIDTH_DEFAULT = 18;
  localparam int unsigned STORE_WIDTH_DEFAULT  = 8;
  localparam int unsigned ADDR_WIDTH_DEFAULT   = 8;

  typedef enum logic [1:0] {
    STATE_ARMED  = 2'd0,
    STATE_ACTIVE = 2'd1,
    STATE_WAIT   = 2'd2
  } state_t;

  // Positive-going crossing: previous sample negative, current non-negative.
  function automatic logic is_crossing(input logic prev_msb, input logic msb);
    return prev_msb & ~msb;
  endfunction

endpackage

// File: rtl/wave_capture_rising_edge_detect.sv
// Rising-edge detector: one flop holding the previous level plus an AND-NOT.
module rising_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise_c
);

  logic level_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign rise_c = level & ~level_q;

endmodule

// File: rtl/wave_capture.sv
// Captures 256 samples after a positive zero crossing into the idle half of a
// double-buffered display RAM, flipping halves when the display goes idle.
module wave_capture
  import wave_capture_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEFAULT,
  parameter int unsigned STORE_WIDTH  = STORE_WIDTH_DEFAULT,
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_sample,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic                    wave_display_idle,
  output logic                    write_enable,
  output logic [ADDR_WIDTH:0]     write_address,
  output logic [STORE_WIDTH-1:0]  write_sample,
  output logic                    read_index
);

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  count;
  logic                   prev_msb;
  logic                   idle_edge;
  logic                   idle_rise_c;
  logic                   sample_msb_c;
  logic                   crossing_c;
  logic [STORE_WIDTH-1:0] store_c;
  logic                   unused_low_bits;

  rising_edge_detect u_idle_edge (
    .clk    (clk),
    .reset  (reset),
    .level  (wave_display_idle),
    .rise_c (idle_rise_c)
  );

  assign sample_msb_c = sample[SAMPLE_WIDTH-1];
  assign crossing_c   = new_sample & is_crossing(prev_msb, sample_msb_c);

  // Offset binary: invert the sign bit and keep the next most significant bits.
  assign store_c = {~sample_msb_c, sample[SAMPLE_WIDTH-2 -: STORE_WIDTH-1]};

  // Bits below the stored field are discarded by truncation.
  assign unused_low_bits = ^sample[SAMPLE_WIDTH-STORE_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= STATE_ARMED;
      count         <= '0;
      prev_msb      <= 1'b0;
      idle_edge     <= 1'b0;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
    end else begin
      write_enable <= 1'b0;
      idle_edge    <= idle_rise_c;
      if (new_sample) begin
        prev_msb <= sample_msb_c;
      end

      case (state)
        STATE_ARMED: begin
          if (crossing_c) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, ADDR_WIDTH'(0)};
            write_sample  <= store_c;
            count         <= ADDR_WIDTH'(1);
            state         <= STATE_ACTIVE;
          end
        end

        STATE_ACTIVE: begin
          if (new_sample) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, count};
            write_sample  <= store_c;
            count         <= count + ADDR_WIDTH'(1);
            if (count == '1) begin
              state <= STATE_WAIT;
            end
          end
        end

        // Only an idle edge evaluated here flips the halves; earlier ones are dropped.
        STATE_WAIT: begin
          if (idle_edge) begin
            read_index <= ~read_index;
            state      <= STATE_ARMED;
          end
        end

        default: begin
          count <= '0;
          state <= STATE_ARMED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_capture.sv
// Randomized bench for wave_capture with a behavioural capture model and a
// write monitor comparing every RAM write against the model's prediction.
module tb_wave_capture;

  localparam int unsigned SW  = 18;
  localparam int unsigned STW = 8;
  localparam int unsigned AW  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          new_sample = 1'b0;
  logic [SW-1:0] sample = '0;
  logic          wave_display_idle = 1'b0;
  logic          write_enable;
  logic [AW:0]   write_address;
  logic [STW-1:0] write_sample;
  logic          read_index;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;

  logic [AW+STW:0] exp_q[$];
  logic [AW+STW:0] exp_w;

  // Model: capture progress, waiting-for-display flag, last sign, displayed half.
  bit m_active = 1'b0;
  bit m_wait   = 1'b0;
  bit m_prev   = 1'b0;
  bit m_rd     = 1'b0;
  int m_count  = 0;

  wave_capture #(
    .SAMPLE_WIDTH (SW),
    .STORE_WIDTH  (STW),
    .ADDR_WIDTH   (AW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample        (new_sample),
    .sample            (sample),
    .wave_display_idle (wave_display_idle),
    .write_enable      (write_enable),
    .write_address     (write_address),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_active = 1'b0;
    m_wait   = 1'b0;
    m_prev   = 1'b0;
    m_rd     = 1'b0;
    m_count  = 0;
    exp_q.delete();
  endfunction

  function automatic void model_sample(input logic [SW-1:0] s);
    bit       negative = s[SW-1];
    int       value    = int'($signed(s));
    logic [STW-1:0] data = STW'((value >>> (SW - STW)) + 128);
    bit       do_write = 1'b0;
    if (m_active) begin
      do_write = 1'b1;
    end else if (!m_wait && m_prev && !negative) begin
      do_write = 1'b1;
      m_active = 1'b1;
      m_count  = 0;
    end
    if (do_write) begin
      exp_q.push_back({(AW+1)'((m_rd ? 0 : 256) + m_count), data});
      m_count++;
      if (m_count == 256) begin
        m_active = 1'b0;
        m_wait   = 1'b1;
      end
    end
    m_prev = negative;
  endfunction

  task automatic send(input logic [SW-1:0] s, input int gap);
    @(negedge clk);
    sample     = s;
    new_sample = 1'b1;
    model_sample(s);
    @(negedge clk);
    new_sample = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic raise_idle();
    @(negedge clk);
    wave_display_idle = 1'b1;
    if (m_wait) begin
      m_rd   = ~m_rd;
      m_wait = 1'b0;
    end
  endtask

  task automatic lower_idle();
    @(negedge clk);
    wave_display_idle = 1'b0;
  endtask

  function automatic logic [SW-1:0] rand_pos();
    return {1'b0, (SW-1)'($urandom)};
  endfunction

  function automatic logic [SW-1:0] rand_neg();
    return {1'b1, (SW-1)'($urandom)};
  endfunction

  task automatic run_capture(input int fixed_gap);
    send(rand_neg(), 2);
    send(rand_pos(), 2);
    for (int i = 0; i < 255; i++) begin
      send(SW'($urandom), (fixed_gap != 0) ? fixed_gap : int'($urandom_range(4, 2)));
    end
  endtask

  // Every write pulse must match the oldest predicted write.
  always @(negedge clk) begin
    if (reset && write_enable) begin
      n_writes++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write",
                 write_address, write_sample);
      end else begin
        exp_w = exp_q.pop_front();
        if ({write_address, write_sample} !== exp_w) begin
          n_errors++;
          $display("FAIL write_content: got addr %h data %h, required addr %h data %h",
                   write_address, write_sample, exp_w[AW+STW:STW], exp_w[STW-1:0]);
        end
      end
    end
  end

  task automatic test_reset();
    int w0;
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks += 4;
    if (write_enable !== 1'b0) begin n_errors++; $display("FAIL reset_we: got %b, required 0", write_enable); end
    if (write_address !== '0) begin n_errors++; $display("FAIL reset_addr: got %h, required 000", write_address); end
    if (write_sample !== '0) begin n_errors++; $display("FAIL reset_data: got %h, required 00", write_sample); end
    if (read_index !== 1'b0) begin n_errors++; $display("FAIL reset_rd: got %b, required 0", read_index); end
    @(negedge clk);
    reset = 1'b1;
    send(SW'(-5), 2);
    send(SW'(3), 2);
    for (int i = 0; i < 40; i++) send(SW'($urandom), 3);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    n_checks += 4;
    if (write_enable !== 1'b0) begin n_errors++; $display("FAIL midreset_we: got %b, required 0", write_enable); end
    if (write_address !== '0) begin n_errors++; $display("FAIL midreset_addr: got %h, required 000", write_address); end
    if (write_sample !== '0) begin n_errors++; $display("FAIL midreset_data: got %h, required 00", write_sample); end
    if (read_index !== 1'b0) begin n_errors++; $display("FAIL midreset_rd: got %b, required 0", read_index); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    w0 = n_writes;
    for (int i = 0; i < 6; i++) send(rand_pos(), 2);
    n_checks++;
    if (n_writes - w0 !== 0) begin
      n_errors++;
      $display("FAIL post_reset_writes: got %0d, required 0", n_writes - w0);
    end
  endtask

  task automatic test_no_crossing();
    int w0 = n_writes;
    for (int i = 0; i < 20; i++) send(rand_pos(), int'($urandom_range(4, 2)));
    for (int i = 0; i < 10; i++) send(rand_neg(), int'($urandom_range(4, 2)));
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_writes - w0 !== 0) begin
      n_errors++;
      $display("FAIL no_crossing_writes: got %0d, required 0", n_writes - w0);
    end
  endtask

  task automatic test_crossing();
    int w0 = n_writes;
    send(SW'(-5), 2);
    n_checks++;
    if (write_enable !== 1'b0) begin
      n_errors++;
      $display("FAIL crossing_neg_we: got %b, required 0", write_enable);
    end
    send(SW'(3), 2);
    n_checks += 2;
    if (write_enable !== 1'b1 || write_address !== 9'h100) begin
      n_errors++;
      $display("FAIL crossing_first_addr: got we %b addr %h, required we 1 addr 100",
               write_enable, write_address);
    end
    if (write_sample !== 8'h80) begin
      n_errors++;
      $display("FAIL crossing_first_data: got %h, required 80", write_sample);
    end
    for (int i = 0; i < 255; i++) send(SW'($urandom), int'($urandom_range(4, 2)));
    repeat (4) @(negedge clk);
    n_checks += 3;
    if (n_writes - w0 !== 256) begin
      n_errors++;
      $display("FAIL crossing_count: got %0d, required 256", n_writes - w0);
    end
    if (exp_q.size() !== 0) begin
      n_errors++;
      $display("FAIL crossing_missing: got %0d pending, required 0", exp_q.size());
    end
    if (read_index !== 1'b0) begin
      n_errors++;
      $display("FAIL crossing_rd: got %b, required 0", read_index);
    end
  endtask

  task automatic test_flip();
    int w0;
    raise_idle();
    @(negedge clk);
    n_checks++;
    if (read_index !== 1'b0) begin n_errors++; $display("FAIL flip_early: got %b, required 0", read_index); end
    @(negedge clk);
    n_checks++;
    if (read_index !== 1'b1) begin n_errors++; $display("FAIL flip_rd: got %b, required 1", read_index); end
    lower_idle();
    w0 = n_writes;
    run_capture(0);
    repeat (4) @(negedge clk);
    n_checks += 2;
    if (n_writes - w0 !== 256) begin
      n_errors++;
      $display("FAIL flip_capture_count: got %0d, required 256", n_writes - w0);
    end
    if (write_address !== 9'h0FF) begin
      n_errors++;
      $display("FAIL flip_last_addr: got %h, required 0ff", write_address);
    end
  endtask

  task automatic test_premature_idle();
    logic rd0;
    raise_idle();
    repeat (2) @(negedge clk);
    lower_idle();
    n_checks++;
    if (read_index !== m_rd) begin n_errors++; $display("FAIL premature_setup_rd: got %b, required %b", read_index, m_rd); end
    send(rand_neg(), 2);
    send(rand_pos(), 2);
    for (int i = 0; i < 99; i++) send(SW'($urandom), 2);
    rd0 = m_rd;
    raise_idle();
    for (int i = 0; i < 156; i++) send(SW'($urandom), int'($urandom_range(4, 2)));
    repeat (6) @(negedge clk);
    n_checks += 2;
    if (read_index !== rd0) begin n_errors++; $display("FAIL premature_flip: got %b, required %b", read_index, rd0); end
    if (exp_q.size() !== 0) begin n_errors++; $display("FAIL premature_missing: got %0d pending, required 0", exp_q.size()); end
    lower_idle();
    raise_idle();
    repeat (2) @(negedge clk);
    n_checks++;
    if (read_index !== ~rd0) begin n_errors++; $display("FAIL premature_late_flip: got %b, required %b", read_index, ~rd0); end
    lower_idle();
  endtask

  task automatic test_coincident_idle();
    logic rd0;
    send(rand_neg(), 2);
    send(rand_pos(), 2);
    for (int i = 0; i < 254; i++) send(SW'($urandom), int'($urandom_range(4, 2)));
    rd0 = m_rd;
    raise_idle();
    send(SW'($urandom), 2);
    repeat (6) @(negedge clk);
    n_checks += 2;
    if (read_index !== rd0) begin n_errors++; $display("FAIL coincident_flip: got %b, required %b", read_index, rd0); end
    if (!m_wait) begin n_errors++; $display("FAIL coincident_model_wait: got 0, required 1"); end
    lower_idle();
    raise_idle();
    @(negedge clk);
    n_checks++;
    if (read_index !== rd0) begin n_errors++; $display("FAIL coincident_early: got %b, required %b", read_index, rd0); end
    @(negedge clk);
    n_checks++;
    if (read_index !== ~rd0) begin n_errors++; $display("FAIL coincident_late_flip: got %b, required %b", read_index, ~rd0); end
    lower_idle();
  endtask

  task automatic test_back_to_back();
    int w0 = n_writes;
    int sent = 0;
    while (!m_wait && sent < 3000) begin
      send(SW'($urandom), 2);
      sent++;
    end
    repeat (4) @(negedge clk);
    n_checks += 3;
    if (!m_wait) begin n_errors++; $display("FAIL b2b_timeout: got no full capture in %0d samples, required one", sent); end
    if (n_writes - w0 !== 256) begin n_errors++; $display("FAIL b2b_count: got %0d, required 256", n_writes - w0); end
    if (exp_q.size() !== 0) begin n_errors++; $display("FAIL b2b_missing: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_no_crossing();
    test_crossing();
    test_flip();
    test_premature_idle();
    test_coincident_idle();
    raise_idle();
    repeat (2) @(negedge clk);
    lower_idle();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
# wave_capture

Capture stage between the music player's flopped sample stream and the wave display's sample RAM. Waits for a positive-going zero crossing of the 18-bit signed audio sample and writes the next 256 samples, truncated to 8-bit offset-binary, into one half of a double-buffered RAM. Once the display signals it is idle, the active half flips so the display reads the newest capture. Runs on the 100 MHz system clock.

## Interface
Parameters:
- SAMPLE_WIDTH, 18, width of the incoming signed sample
- STORE_WIDTH, 8, width of the stored display sample
- ADDR_WIDTH, 8, address bits per buffer half (DEPTH = 2^ADDR_WIDTH = 256)

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-low reset; one clock domain only
- new_sample  in  1  one-cycle strobe, sample valid this cycle
- sample  in  SAMPLE_WIDTH  signed two's-complement audio sample
- wave_display_idle  in  1  high while the display is outside the visible region (vsync-derived level)
- write_enable  out  1  one-cycle RAM write strobe
- write_address  out  ADDR_WIDTH+1  {~read_index, sample index}
- write_sample  out  STORE_WIDTH  {~sample[17], sample[16:10]}, i.e. offset binary
- read_index  out  1  buffer half the display currently reads

## Operation
- States: ARMED, ACTIVE, WAIT.
- prev_msb register holds sample[SAMPLE_WIDTH-1] of the last accepted sample. It updates on every new_sample in all states.
- Zero crossing: new_sample && prev_msb==1 && sample[MSB]==0.
- ARMED: on a crossing, write the crossing sample at index 0, set count=1, and go to ACTIVE. On a non-crossing new_sample, no write.
- ACTIVE: on each new_sample, write at index count and increment count. The sample written at index 255 moves the block to WAIT, with count wrapping to 0.
- WAIT: samples are not written. On a rising edge of wave_display_idle, toggle read_index and go to ARMED.
- A rising edge of idle seen in ARMED or ACTIVE is ignored and not remembered. The buffer flips only after a complete 256-sample capture.
- Writes always go to the half not being read (~read_index). The display never sees a partial capture.
- Reset (asserted at any time, including mid-capture):
  - state=ARMED, count=0, prev_msb=0, read_index=0
  - write_enable=0, write_address=0, write_sample=0
  - idle edge register=0
  - The first sample after reset can never be a crossing.

## Timing
- All outputs are registered. write_enable, write_address and write_sample are valid in the cycle after the qualifying new_sample and held until the next write.
- write_enable is high for exactly one cycle per written sample.
- new_sample strobes are at least 2 cycles apart (codec rate). Back-to-back strobes are still handled: one write per strobe, no drops.
- Idle edge detect uses a registered copy of wave_display_idle. read_index toggles 2 cycles after idle rises, provided the block is in WAIT when the registered edge is evaluated.
- If the 255th write and an idle rise coincide, the edge is not captured. The block waits in WAIT for the next rise.
- Arithmetic: count is ADDR_WIDTH bits and wraps naturally. No sign extension is needed; truncation takes the top STORE_WIDTH bits.

## Structure
- Shared package/header: state encodings STATE_ARMED=2'd0, STATE_ACTIVE=2'd1, STATE_WAIT=2'd2. Unused encoding 2'd3 returns to ARMED.
- Sub-module: rising_edge_detect (flop plus AND-NOT, async active-low reset) for wave_display_idle.
- Remaining logic: the FSM, count, prev_msb and output registers, using the existing dff style with explicit async reset.

## Test plan
- Reset check: hold reset low mid-ACTIVE, then release. All outputs are 0, read_index=0, and no write occurs until a fresh crossing.
- Crossing capture: feed samples -5, +3, then 255 more. Expect:
  - first write at address 9'h100 with data {1,+3[16:10]}
  - addresses 0x100..0x1FF in order
  - exactly 256 write_enable pulses
- No crossing: feed only positive samples, or a +→− transition. Expect zero writes and the state stays ARMED.
- Flip: after a full capture, pulse wave_display_idle high. Expect read_index 0→1 two cycles later; the next capture writes addresses 0x000..0x0FF.
- Premature idle: raise idle during ACTIVE at write 100 and keep it high. Expect no flip; the flip happens on the next idle rise after WAIT is entered.
- Back-to-back: new_sample strobes every 2 cycles through a full capture. Expect 256 writes and no dropped index.
